// File: rtl/alu_defs.sv
// Shared definitions for the sequenced ALU: op encodings, FSM states, default width.
package alu_defs;

  localparam int XLEN_DEF = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one position per step, counter reports when the shift amount is used up.
module alu_serial_shifter #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [XLEN-1:0]    load_val_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               left_i,
  input  logic               arith_i,
  output logic [XLEN-1:0]    acc_o,
  output logic               cnt_zero_o
);

  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               arith_q, arith_d;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (load_i) begin
      acc_d   = load_val_i;
      cnt_d   = shamt_i;
      left_d  = left_i;
      arith_d = arith_i;
    end else if (step_i && (cnt_q != '0)) begin
      if (left_q) begin
        acc_d = {acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {(arith_q ? acc_q[XLEN-1] : 1'b0), acc_q[XLEN-1:1]};
      end
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

  assign acc_o      = acc_q;
  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered integer ALU with req/ready/done handshake; single-cycle arithmetic/logic,
// bit-serial shifts. state | meaning: IDLE | ready, 1-cycle ops ; SHIFT | serial shift running
module alu_seq
  import alu_defs::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter bit WORD_EN = 1'b1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic            word_i,
  input  logic            cin_i,
  input  logic [XLEN-1:0] inA_i,
  input  logic [XLEN-1:0] inB_i,
  output logic [XLEN-1:0] out_o,
  output logic            done_o,
  output logic            cflag_o,
  output logic            vflag_o,
  output logic            zflag_o
);

  localparam bit WORD_OK = WORD_EN && (XLEN == 64);
  localparam int WW      = (XLEN >= 32) ? 32 : XLEN;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = WW; i < XLEN; i++) r[i] = x[WW-1];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = WW; i < XLEN; i++) r[i] = 1'b0;
    return r;
  endfunction

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            c_q, c_d, v_q, v_d, z_q, z_d;
  logic            done_q, done_d;
  logic            word_q, word_d;

  alu_op_e         op;
  logic            word_mode;
  logic            is_shift;
  logic [XLEN-1:0] b_eff;
  logic            cin_eff;
  logic [XLEN:0]   sum_x;
  logic [WW:0]     sum_w;
  logic [XLEN-1:0] logic_r;
  logic            lt;
  logic [XLEN-1:0] alu_res;
  logic            alu_c, alu_v;

  logic               sh_load, sh_step, sh_left, sh_arith, sh_cnt_zero;
  logic [XLEN-1:0]    sh_val, sh_acc, shift_fin;
  logic [SHAMT_W-1:0] sh_shamt;

  assign op        = alu_op_e'(op_i);
  assign word_mode = WORD_OK && word_i;
  assign is_shift  = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);

  always_comb begin
    b_eff   = inB_i;
    cin_eff = 1'b0;
    logic_r = '0;
    lt      = 1'b0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    if (op == ALU_SUB) begin
      b_eff   = ~inB_i;
      cin_eff = 1'b1;
    end else if (op == ALU_ADD) begin
      cin_eff = cin_i;
    end
    sum_x = {1'b0, inA_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin_eff};
    sum_w = {1'b0, inA_i[WW-1:0]} + {1'b0, b_eff[WW-1:0]} + {{WW{1'b0}}, cin_eff};
    case (op)
      ALU_ADD, ALU_SUB: begin
        // Overflow is carry into the top bit XOR carry out of it.
        if (word_mode) begin
          alu_res = sext_w(XLEN'(sum_w[WW-1:0]));
          alu_c   = sum_w[WW];
          alu_v   = inA_i[WW-1] ^ b_eff[WW-1] ^ sum_w[WW-1] ^ sum_w[WW];
        end else begin
          alu_res = sum_x[XLEN-1:0];
          alu_c   = sum_x[XLEN];
          alu_v   = inA_i[XLEN-1] ^ b_eff[XLEN-1] ^ sum_x[XLEN-1] ^ sum_x[XLEN];
        end
      end
      ALU_AND, ALU_OR, ALU_XOR: begin
        if (op == ALU_AND)     logic_r = inA_i & inB_i;
        else if (op == ALU_OR) logic_r = inA_i | inB_i;
        else                   logic_r = inA_i ^ inB_i;
        alu_res = word_mode ? sext_w(logic_r) : logic_r;
      end
      ALU_SLT: begin
        lt = word_mode ? ($signed(inA_i[WW-1:0]) < $signed(inB_i[WW-1:0]))
                       : ($signed(inA_i) < $signed(inB_i));
        alu_res[0] = lt;
      end
      ALU_SLTU: begin
        lt = word_mode ? (inA_i[WW-1:0] < inB_i[WW-1:0]) : (inA_i < inB_i);
        alu_res[0] = lt;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    sh_left  = (op == ALU_SLL);
    sh_arith = (op == ALU_SRA);
    if (op == ALU_SRL) sh_val = word_mode ? zext_w(inA_i) : inA_i;
    else               sh_val = word_mode ? sext_w(inA_i) : inA_i;
    sh_shamt = inB_i[SHAMT_W-1:0];
    if (word_mode) sh_shamt = sh_shamt & SHAMT_W'(31);
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (sh_load),
    .step_i     (sh_step),
    .load_val_i (sh_val),
    .shamt_i    (sh_shamt),
    .left_i     (sh_left),
    .arith_i    (sh_arith),
    .acc_o      (sh_acc),
    .cnt_zero_o (sh_cnt_zero)
  );

  assign shift_fin = word_q ? sext_w(sh_acc) : sh_acc;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    done_d  = 1'b0;
    word_d  = word_q;
    sh_load = 1'b0;
    sh_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (is_shift) begin
            sh_load = 1'b1;
            word_d  = word_mode;
            state_d = ST_SHIFT;
          end else begin
            out_d  = alu_res;
            c_d    = alu_c;
            v_d    = alu_v;
            z_d    = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_cnt_zero) begin
          out_d   = shift_fin;
          c_d     = 1'b0;
          v_d     = 1'b0;
          z_d     = (shift_fin == '0);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sh_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      done_q  <= done_d;
      word_q  <= word_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign out_o   = out_q;
  assign done_o  = done_q;
  assign cflag_o = c_q;
  assign vflag_o = v_q;
  assign zflag_o = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: arithmetic reference model, decoupled done_o monitor.
module tb_alu_seq;

  localparam logic signed [65:0] MAX64 = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MIN64 = -66'sh0_8000_0000_0000_0000;
  localparam logic signed [65:0] MAX32 = 66'sh0_0000_0000_7FFF_FFFF;
  localparam logic signed [65:0] MIN32 = -66'sh0_0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic        word_i = 1'b0;
  logic        cin_i = 1'b0;
  logic [63:0] inA_i = '0;
  logic [63:0] inB_i = '0;
  logic        ready_o, done_o, cflag_o, vflag_o, zflag_o;
  logic [63:0] out_o;

  alu_seq #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .req_i   (req_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .word_i  (word_i),
    .cin_i   (cin_i),
    .inA_i   (inA_i),
    .inB_i   (inB_i),
    .out_o   (out_o),
    .done_o  (done_o),
    .cflag_o (cflag_o),
    .vflag_o (vflag_o),
    .zflag_o (zflag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic        c, v, z;
    int          done_cyc;
  } exp_t;

  exp_t scb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic rst_edge = 1'b1;
  logic [66:0] prev_obs = '0;

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset_i;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic exp_t model(input int op, input bit word, input bit cin,
                                 input logic [63:0] a, input logic [63:0] b, input int k);
    exp_t e;
    logic [31:0] a32, b32, r32;
    logic [32:0] s33;
    logic [64:0] s65;
    logic [63:0] r;
    logic signed [65:0] t, sa, sbv;
    int sh;
    a32 = a[31:0];
    b32 = b[31:0];
    e.out = '0; e.c = 1'b0; e.v = 1'b0; e.done_cyc = k;
    if (word) begin
      sa  = $signed({{34{a32[31]}}, a32});
      sbv = $signed({{34{b32[31]}}, b32});
    end else begin
      sa  = $signed({{2{a[63]}}, a});
      sbv = $signed({{2{b[63]}}, b});
    end
    case (op)
      0: begin
        t = sa + sbv;
        if (cin) t = t + 66'sd1;
        if (word) begin
          s33 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin};
          e.out = sx32(s33[31:0]); e.c = s33[32]; e.v = (t > MAX32) || (t < MIN32);
        end else begin
          s65 = {1'b0, a} + {1'b0, b} + {64'd0, cin};
          e.out = s65[63:0]; e.c = s65[64]; e.v = (t > MAX64) || (t < MIN64);
        end
      end
      1: begin
        t = sa - sbv;
        if (word) begin
          r32 = a32 - b32;
          e.out = sx32(r32); e.c = (a32 >= b32); e.v = (t > MAX32) || (t < MIN32);
        end else begin
          e.out = a - b; e.c = (a >= b); e.v = (t > MAX64) || (t < MIN64);
        end
      end
      2, 3, 4: begin
        r = (op == 2) ? (a & b) : (op == 3) ? (a | b) : (a ^ b);
        e.out = word ? sx32(r[31:0]) : r;
      end
      5: e.out = {63'd0, (word ? ($signed(a32) < $signed(b32)) : ($signed(a) < $signed(b)))};
      6: e.out = {63'd0, (word ? (a32 < b32) : (a < b))};
      7, 8, 9: begin
        sh = word ? int'(b[4:0]) : int'(b[5:0]);
        e.done_cyc = k + sh + 1;
        if (op == 7) begin
          if (word) begin r32 = a32 << sh; e.out = sx32(r32); end
          else e.out = a << sh;
        end else if (op == 8) begin
          if (word) begin r32 = a32 >> sh; e.out = sx32(r32); end
          else e.out = a >> sh;
        end else begin
          if (word) begin r32 = $signed(a32) >>> sh; e.out = sx32(r32); end
          else e.out = $signed(a) >>> sh;
        end
      end
      default: e.out = '0;
    endcase
    e.z = (e.out == '0);
    return e;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      n_done++;
      if (scb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 out=%h expected no completion (cycle %0d)", out_o, cyc);
      end else begin
        e = scb.pop_front();
        check("result", out_o, e.out);
        check("cflag", 64'(cflag_o), 64'(e.c));
        check("vflag", 64'(vflag_o), 64'(e.v));
        check("zflag", 64'(zflag_o), 64'(e.z));
        check("latency_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end else if (!rst_edge) begin
      check("hold_without_done", 64'(prev_obs[66:3] != out_o || prev_obs[2:0] != {cflag_o, vflag_o, zflag_o}), 64'd0);
    end
    prev_obs = {out_o, cflag_o, vflag_o, zflag_o};
  end

  task automatic issue(input int op, input bit word, input bit cin,
                       input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 200 cycles");
      return;
    end
    req_i = 1'b1; op_i = op[3:0]; word_i = word; cin_i = cin; inA_i = a; inB_i = b;
    scb.push_back(model(op, word, cin, a, b, cyc + 1));
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return {32'($urandom), 32'h7FFF_FFFF};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int snap;
    int guard;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_out", out_o, 64'd0);
    check("reset_flags", 64'({cflag_o, vflag_o, zflag_o}), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    reset_i = 1'b0;

    issue(0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    issue(0, 0, 1, 64'd0, 64'd0);
    issue(1, 0, 0, 64'd5, 64'd5);
    issue(1, 0, 0, 64'd0, 64'd1);

    issue(7, 0, 0, 64'd1, 64'd63);
    repeat (3) @(negedge clk);
    check("busy_ready_low", 64'(ready_o), 64'd0);
    req_i = 1'b1; op_i = 4'd0; word_i = 1'b0; inA_i = 64'd3; inB_i = 64'd4;
    @(posedge clk);
    #1 req_i = 1'b0;
    issue(8, 0, 0, 64'hDEAD_BEEF_0123_4567, 64'd0);

    issue(9, 1, 0, 64'h0000_0000_8000_0000, 64'd4);
    issue(8, 1, 0, 64'h0000_0000_8000_0000, 64'd4);
    issue(0, 1, 0, 64'h7FFF_FFFF, 64'd1);
    issue(5, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    issue(6, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    issue(12, 0, 0, 64'h1234, 64'h5678);

    issue(7, 0, 0, 64'd1, 64'd10);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    scb.delete();
    @(negedge clk);
    reset_i = 1'b0;
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_out", out_o, 64'd0);
    check("abort_flags", 64'({cflag_o, vflag_o, zflag_o, done_o}), 64'd0);
    snap = n_done;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(n_done - snap), 64'd0);
    for (int i = 0; i < 10; i++) issue(0, 0, i[0], 64'(i * 1000), 64'(i + 7));

    for (int i = 0; i < 250; i++) begin
      issue($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rnd_operand(), rnd_operand());
    end

    guard = 0;
    while (scb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_outstanding", 64'(scb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational integer ALU.
- Widths: XLEN-wide datapath, with optional RV64-style 32-bit "word" mode.
- Ops: add/sub with carry-in, logic ops, signed and unsigned compare.
- Shifts: executed serially, one bit per cycle.
- Interface: sits between the decode/operand stage and writeback, and uses a req/ready/done handshake so the sequencer can stall on long shifts.

Parameters:
XLEN, 64, datapath width in bits (>=8, power of two).
WORD_EN, 1, enables word mode; legal only when XLEN==64, otherwise word_i is ignored.
SHAMT_W, $clog2(XLEN), shift-amount field width taken from inB_i.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  synchronous, active-high reset
req_i  in  1  operation request; accepted on an edge where req_i & ready_o
ready_o  out  1  high when the block can accept a request
op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 reserved
word_i  in  1  word mode: 32-bit operation, result sign-extended to XLEN
cin_i  in  1  carry-in, used by ADD only
inA_i  in  XLEN  operand A
inB_i  in  XLEN  operand B; low SHAMT_W bits are the shift amount (low 5 bits in word mode)
out_o  out  XLEN  registered result, held until the next completion
done_o  out  1  one-cycle pulse: out_o and flags updated this cycle
cflag_o  out  1  carry out (ADD), not-borrow (SUB); 0 for other ops
vflag_o  out  1  signed overflow (ADD/SUB); 0 for other ops
zflag_o  out  1  out_o == 0, registered with the result

Behaviour:
- States are IDLE and SHIFT. ready_o = (state==IDLE).
- Reset: state IDLE, out_o=0, flags=0, done_o=0, shift counter=0. Reset mid-SHIFT aborts the operation; no done_o is ever produced for it.
- Request while not ready: req_i and operands are ignored; no queueing.
- Non-shift op accepted at edge k: result and flags are written at edge k, done_o is high for the following cycle, state stays IDLE. Back-to-back requests every cycle are legal.
- SUB is computed as A + ~B + 1. cflag = carry out of the top bit. vflag = carry into the MSB XOR carry out of the MSB. The top bit is 31 in word mode, XLEN-1 otherwise.
- Word-mode ADD/SUB: sum of the low 32 bits, sign-extended from bit 31.
- SLT/SLTU: result is 0 or 1, zero-extended. Word mode compares the sign-extended (SLT) or zero-extended (SLTU) low 32 bits.
- AND/OR/XOR ignore word_i except for sign-extension of bit 31 in word mode.
- Reserved ops: result 0, flags 0 except zflag=1, latency 1.
- Shift accepted at edge k:
  - Load the accumulator: SLL and SRL take A, SRA takes A. In word mode, SRL loads the low 32 bits zero-extended and SLL/SRA load them sign-extended.
  - Load cnt=shamt. Go to SHIFT.
- In SHIFT, on each edge:
  - If cnt!=0: shift the accumulator by 1 (SRA replicates the MSB) and decrement cnt.
  - If cnt==0: out_o = accumulator (word mode: sign-extend bit 31), flags c=v=0, z computed, done_o pulses, return to IDLE.
- Shift latency: done_o is high in the cycle after edge k+shamt+1, and ready_o is high in that same cycle.
- Shift amounts are masked to SHAMT_W bits (5 in word mode). Shamt 0 takes 2 edges.
- Operands are captured at acceptance; input changes during SHIFT have no effect.
- out_o and flags change only with done_o (or on reset).

Decomposition:
- Shared include/package alu_defs: op encodings (ALU_ADD..ALU_SRA), state encodings, XLEN default.
- One sub-module, alu_serial_shifter: holds the accumulator, counter, direction/arith controls, load and step inputs, and the zero-count output.
- The adder, logic and compare paths stay in alu_seq.

Test Plan:
1. XLEN=64, ADD A=0x7FFFFFFFFFFFFFFF B=1 cin=0 -> out 0x8000000000000000, v=1 c=0 z=0, done_o one cycle after accept; ADD with cin=1 and A=B=0 -> out 1.
2. SUB A=5 B=5 -> out 0, z=1 c=1 v=0; SUB A=0 B=1 -> out 0xFFFFFFFFFFFFFFFF, c=0.
3. SLL A=1 B=63 accepted at edge k -> ready_o low, a req_i at k+3 ignored, done_o after edge k+64, out 0x8000000000000000; SRL B=0 -> done after edge k+1, out=A.
4. Word SRA A=0x0000000080000000 B=4 -> out 0xFFFFFFFFF8000000, done after edge k+5; word SRL same operands -> 0x0000000008000000.
5. Word ADD A=0x7FFFFFFF B=1 -> out 0xFFFFFFFF80000000, v=1; SLT A=-1 B=0 -> 1, SLTU same operands -> 0; op 12 -> out 0, z=1.
6. reset_i pulsed three cycles into SLL A=1 B=10 -> next cycle ready_o=1, out_o=0, flags 0, and no done_o within 20 cycles; ten back-to-back ADDs then all complete with 1-cycle latency.
